// File: rtl/ip_pad_switch_pkg.sv
// Shared types and constants for the pad-ring hand-over controller.
// The optional quiesce timeout is enabled with IP_PAD_SWITCH_TIMEOUT_EN.
package ip_pad_switch_pkg;

    localparam int IP_SEL_W           = 3;
    localparam int PAD_NUM            = 82;
    localparam int GUARD_CYCLES_DEF   = 4;
    localparam int RST_CYCLES_DEF     = 8;
    localparam int TIMEOUT_CYCLES_DEF = 256;

    localparam logic [2:0] S_RELEASE    = 3'd0;
    localparam logic [2:0] S_ACTIVE     = 3'd1;
    localparam logic [2:0] S_QUIESCE    = 3'd2;
    localparam logic [2:0] S_GUARD_PRE  = 3'd3;
    localparam logic [2:0] S_SWITCH     = 3'd4;
    localparam logic [2:0] S_GUARD_POST = 3'd5;

    typedef enum logic [2:0] {
        ST_RELEASE    = S_RELEASE,
        ST_ACTIVE     = S_ACTIVE,
        ST_QUIESCE    = S_QUIESCE,
        ST_GUARD_PRE  = S_GUARD_PRE,
        ST_SWITCH     = S_SWITCH,
        ST_GUARD_POST = S_GUARD_POST
    } sw_state_e;

    // Wide enough to hold the largest phase length itself, not just length-1.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(GUARD_CYCLES_DEF, RST_CYCLES_DEF, TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/ip_pad_switch_ctrl_cnt.sv
// Loadable down-counter with zero flag, shared by the guard, release and
// quiesce-timeout phases of the pad switch controller.
module ip_pad_switch_cnt
    import ip_pad_switch_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ip_pad_switch_ctrl.sv
// Pad-ring hand-over sequencer: quiesce -> force OE off -> switch mux ->
// reset new IP -> release. Optional quiesce timeout: IP_PAD_SWITCH_TIMEOUT_EN.
//
// state      | meaning
// RELEASE    | new IP held in reset, pads still forced to input
// ACTIVE     | current IP owns the pads, ip_sel_i monitored
// QUIESCE    | waiting for the current IP to acknowledge idle
// GUARD_PRE  | OE forced low before the mux switch
// SWITCH     | mux select updated, old and new IP put into reset
// GUARD_POST | OE forced low after the mux switch
module ip_pad_switch_ctrl
    import ip_pad_switch_pkg::*;
#(
    parameter int NUM_IP         = 3,
    parameter int GUARD_CYCLES   = GUARD_CYCLES_DEF,
    parameter int RST_CYCLES     = RST_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [IP_SEL_W-1:0] ip_sel_i,
    input  logic [NUM_IP-1:0]   quiesce_ack_i,
    output logic [NUM_IP-1:0]   quiesce_req_o,
    output logic [IP_SEL_W-1:0] mux_sel_o,
    output logic                oe_force_off_o,
    output logic [NUM_IP-1:0]   ip_rst_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                sel_err_o,
    output logic                timeout_o
);

`ifdef IP_PAD_SWITCH_TIMEOUT_EN
    localparam int TO_LEN = TIMEOUT_CYCLES;
`else
    localparam int TO_LEN = (TIMEOUT_CYCLES > 0) ? 1 : 1;
`endif
    localparam int CNT_W = cnt_width(GUARD_CYCLES, RST_CYCLES, TO_LEN);
    localparam logic [IP_SEL_W:0] NUM_IP_V = (IP_SEL_W + 1)'(NUM_IP);

    sw_state_e             state_q, state_d;
    logic [IP_SEL_W-1:0]   cur_sel, tgt_sel;
    logic [NUM_IP-1:0]     cur_oh, tgt_oh;
    logic                  ack_cur, sel_illegal, sel_change;
    logic                  counted, cnt_run_q, cnt_done, cnt_zero, cnt_load, cnt_dec;
    logic                  to_expire;
    logic [CNT_W-1:0]      cnt_len;

    assign cur_oh      = NUM_IP'(1) << cur_sel;
    assign tgt_oh      = NUM_IP'(1) << tgt_sel;
    assign ack_cur     = |(quiesce_ack_i & cur_oh);
    assign sel_illegal = ({1'b0, ip_sel_i} >= NUM_IP_V);
    assign sel_change  = (ip_sel_i != cur_sel) && !sel_illegal;

    always_comb begin
        counted = 1'b0;
        cnt_len = CNT_W'(1);
        case (state_q)
            ST_RELEASE:    begin counted = 1'b1; cnt_len = CNT_W'(RST_CYCLES);   end
            ST_GUARD_PRE,
            ST_GUARD_POST: begin counted = 1'b1; cnt_len = CNT_W'(GUARD_CYCLES); end
`ifdef IP_PAD_SWITCH_TIMEOUT_EN
            ST_QUIESCE:    begin counted = 1'b1; cnt_len = CNT_W'(TO_LEN);       end
`endif
            default: ;
        endcase
    end

    // The first cycle of a counted phase loads length-2, so the zero flag
    // lands exactly on the phase's last cycle; length 1 finishes immediately.
    assign cnt_done = counted && (cnt_run_q ? cnt_zero : (cnt_len == CNT_W'(1)));
    assign cnt_load = counted && !cnt_run_q && !cnt_done;
    assign cnt_dec  = counted && cnt_run_q;

`ifdef IP_PAD_SWITCH_TIMEOUT_EN
    assign to_expire = cnt_done;
`else
    assign to_expire = 1'b0;
`endif

    ip_pad_switch_cnt #(.W(CNT_W)) u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_len - CNT_W'(2)),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RELEASE:    if (cnt_done) state_d = ST_ACTIVE;
            ST_ACTIVE:     if (sel_change) state_d = ST_QUIESCE;
            ST_QUIESCE:    if (ack_cur || to_expire) state_d = ST_GUARD_PRE;
            ST_GUARD_PRE:  if (cnt_done) state_d = ST_SWITCH;
            ST_SWITCH:     state_d = ST_GUARD_POST;
            ST_GUARD_POST: if (cnt_done) state_d = ST_RELEASE;
            default:       state_d = ST_RELEASE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_RELEASE;
            cnt_run_q      <= 1'b0;
            cur_sel        <= '0;
            tgt_sel        <= '0;
            mux_sel_o      <= '0;
            oe_force_off_o <= 1'b1;
            ip_rst_o       <= '1;
            quiesce_req_o  <= '0;
            busy_o         <= 1'b1;
            done_o         <= 1'b0;
            sel_err_o      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_run_q <= counted && (state_d == state_q);
            done_o    <= 1'b0;
            case (state_q)
                ST_RELEASE: begin
                    if (cnt_done) begin
                        ip_rst_o       <= ip_rst_o & ~tgt_oh;
                        oe_force_off_o <= 1'b0;
                        busy_o         <= 1'b0;
                        done_o         <= 1'b1;
                        cur_sel        <= tgt_sel;
                    end
                end
                ST_ACTIVE: begin
                    if (sel_illegal) begin
                        sel_err_o <= 1'b1;
                    end else if (sel_change) begin
                        tgt_sel       <= ip_sel_i;
                        busy_o        <= 1'b1;
                        quiesce_req_o <= cur_oh;
                    end
                end
                ST_QUIESCE: begin
                    if (ack_cur || to_expire) begin
                        quiesce_req_o  <= '0;
                        oe_force_off_o <= 1'b1;
                    end
                end
                ST_SWITCH: begin
                    ip_rst_o  <= ip_rst_o | cur_oh | tgt_oh;
                    mux_sel_o <= tgt_sel;
                end
                default: ;
            endcase
        end
    end

`ifdef IP_PAD_SWITCH_TIMEOUT_EN
    // An ack arriving in the expiry cycle wins over the timeout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timeout_o <= 1'b0;
        end else if ((state_q == ST_QUIESCE) && to_expire && !ack_cur) begin
            timeout_o <= 1'b1;
        end
    end
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_ip_pad_switch_ctrl.sv
// Self-checking bench for ip_pad_switch_ctrl: directed hand-over scenarios
// plus randomized traffic against a timestamp-based reference model.
module tb_ip_pad_switch_ctrl;

    localparam int NUM_IP = 3;
    localparam int G      = 4;
    localparam int R      = 8;
    localparam int T      = 256;
`ifdef IP_PAD_SWITCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int PH_ACT = 0;
    localparam int PH_QUI = 1;
    localparam int PH_SEQ = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [2:0]        ip_sel_i;
    logic [NUM_IP-1:0] quiesce_ack_i;
    logic [NUM_IP-1:0] quiesce_req_o;
    logic [2:0]        mux_sel_o;
    logic              oe_force_off_o;
    logic [NUM_IP-1:0] ip_rst_o;
    logic              busy_o, done_o, sel_err_o, timeout_o;

    ip_pad_switch_ctrl #(
        .NUM_IP(NUM_IP), .GUARD_CYCLES(G), .RST_CYCLES(R), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ip_sel_i       (ip_sel_i),
        .quiesce_ack_i  (quiesce_ack_i),
        .quiesce_req_o  (quiesce_req_o),
        .mux_sel_o      (mux_sel_o),
        .oe_force_off_o (oe_force_off_o),
        .ip_rst_o       (ip_rst_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .sel_err_o      (sel_err_o),
        .timeout_o      (timeout_o)
    );

    always #20 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    // Reference model: phase plus event timestamps (accept edge, quiesce-end edge).
    int                m_phase, m_cur, m_tgt, m_ta, m_tq;
    logic [NUM_IP-1:0] m_req, m_rst;
    logic [2:0]        m_mux;
    bit                m_oe, m_busy, m_done, m_err, m_to;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_edge();
        bit q_ack;
        edge_n++;
        m_done = 1'b0;
        if (rst_i) begin
            m_cur = 0; m_tgt = 0; m_mux = 3'd0; m_oe = 1'b1; m_rst = '1; m_req = '0;
            m_busy = 1'b1; m_err = 1'b0; m_to = 1'b0;
            m_phase = PH_SEQ;
            m_tq = edge_n - (2 * G + 1);
        end else begin
            case (m_phase)
                PH_ACT: begin
                    if (int'(ip_sel_i) != m_cur) begin
                        if (int'(ip_sel_i) >= NUM_IP) begin
                            m_err = 1'b1;
                        end else begin
                            m_tgt = int'(ip_sel_i);
                            m_busy = 1'b1;
                            m_req = '0;
                            m_req[m_cur] = 1'b1;
                            m_ta = edge_n;
                            m_phase = PH_QUI;
                        end
                    end
                end
                PH_QUI: begin
                    q_ack = quiesce_ack_i[m_cur];
                    if (q_ack || (TO_EN && (edge_n - m_ta >= T))) begin
                        if (!q_ack) m_to = 1'b1;
                        m_req = '0;
                        m_oe = 1'b1;
                        m_tq = edge_n;
                        m_phase = PH_SEQ;
                    end
                end
                default: begin
                    if (edge_n == m_tq + G + 1) begin
                        m_mux = 3'(m_tgt);
                        m_rst[m_cur] = 1'b1;
                        m_rst[m_tgt] = 1'b1;
                    end
                    if (edge_n == m_tq + 2 * G + 1 + R) begin
                        m_rst[m_tgt] = 1'b0;
                        m_oe = 1'b0;
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        m_cur = m_tgt;
                        m_phase = PH_ACT;
                    end
                end
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        model_edge();
        chk("quiesce_req", 16'(quiesce_req_o), 16'(m_req));
        chk("mux_sel", 16'(mux_sel_o), 16'(m_mux));
        chk("oe_force_off", 16'(oe_force_off_o), 16'(m_oe));
        chk("ip_rst", 16'(ip_rst_o), 16'(m_rst));
        chk("busy", 16'(busy_o), 16'(m_busy));
        chk("done", 16'(done_o), 16'(m_done));
        chk("sel_err", 16'(sel_err_o), 16'(m_err));
        chk("timeout", 16'(timeout_o), 16'(m_to));
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!done_o && (n < budget));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog edge=%0d", edge_n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_i = 1'b1; ip_sel_i = 3'd0; quiesce_ack_i = '0;
        step(); step();
        rst_i = 1'b0;

        for (int i = 0; i < R; i++) step();
        chk("boot_done", 16'(done_o), 16'd1);
        chk("boot_ip_rst", 16'(ip_rst_o), 16'b110);
        chk("boot_oe", 16'(oe_force_off_o), 16'd0);
        chk("boot_mux", 16'(mux_sel_o), 16'd0);

        quiesce_ack_i = '1;
        ip_sel_i = 3'd1;
        wait_done(40, n);
        chk("lat_0_1", 16'(n), 16'd19);
        chk("mux_after_0_1", 16'(mux_sel_o), 16'd1);
        chk("ip_rst_after_0_1", 16'(ip_rst_o), 16'b101);

        quiesce_ack_i = '0;
        ip_sel_i = 3'd2;
        for (int i = 0; i < 51; i++) step();
        chk("mux_hold_no_ack", 16'(mux_sel_o), 16'd1);
        chk("oe_hold_no_ack", 16'(oe_force_off_o), 16'd0);
        quiesce_ack_i = '1;
        wait_done(40, n);
        chk("lat_1_2_delayed", 16'(n + 51), 16'd69);

        ip_sel_i = 3'd0;
        wait_done(40, n);
        chk("lat_2_0", 16'(n), 16'd19);
        ip_sel_i = 3'd5;
        step();
        chk("illegal_err", 16'(sel_err_o), 16'd1);
        chk("illegal_busy", 16'(busy_o), 16'd0);
        for (int i = 0; i < 3; i++) step();
        ip_sel_i = 3'd0;
        step();
        chk("illegal_sticky", 16'(sel_err_o), 16'd1);
        chk("illegal_mux", 16'(mux_sel_o), 16'd0);

        ip_sel_i = 3'd1;
        for (int i = 0; i < 3; i++) step();
        ip_sel_i = 3'd2;
        wait_done(40, n);
        chk("lat_mid_change", 16'(n + 3), 16'd19);
        chk("mid_change_mux", 16'(mux_sel_o), 16'd1);
        step();
        chk("restart_busy", 16'(busy_o), 16'd1);
        chk("restart_req", 16'(quiesce_req_o), 16'b010);
        wait_done(40, n);
        chk("lat_restart", 16'(n), 16'd18);

        quiesce_ack_i = '0;
        ip_sel_i = 3'd0;
        for (int i = 0; i < 300; i++) step();
        chk("to_flag", 16'(timeout_o), 16'(TO_EN));
        chk("to_busy", 16'(busy_o), 16'(!TO_EN));
        quiesce_ack_i = '1;
        for (int i = 0; i < 25; i++) step();

        for (int c = 0; c < 2500; c++) begin
            rst_i = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 15) == 0) ip_sel_i = 3'($urandom_range(0, 7));
            quiesce_ack_i = NUM_IP'($urandom) & NUM_IP'($urandom);
            step();
        end

        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        for (int i = 0; i < R + 2; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
